execute_unit: RTL

EXECUTE_UNIT -- requirements
Module: execute_unit

---
 rtl/exe_pkg.sv | 30 +++
 rtl/exe_muldiv.sv | 92 +++++++++
 rtl/execute_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: opcodes, forwarding selects and
// the MUL/DIV sequencing states.
package exe_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SHIFT = 4'h5;
  localparam logic [3:0] OP_SLT   = 4'h6;
  localparam logic [3:0] OP_BEQ   = 4'h7;
  localparam logic [3:0] OP_BNE   = 4'h8;
  localparam logic [3:0] OP_MUL   = 4'hE;
  localparam logic [3:0] OP_DIV   = 4'hF;

  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } exe_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/exe_muldiv.sv
// Iterative MUL/DIV engine: shift-add multiply (low WIDTH bits) and restoring
// divide on magnitudes, one bit per cycle for WIDTH cycles.
module exe_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_abort,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);
  import exe_pkg::*;

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_div;
  logic             r_neg;
  logic             r_dz;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;

  // Operand magnitudes and one restoring-divide trial subtraction
  always_comb begin
    w_a_mag  = i_a[WIDTH-1] ? -i_a : i_a;
    w_b_mag  = i_b[WIDTH-1] ? -i_b : i_b;
    w_rem_sh = {r_acc, r_q[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_d};
  end

  // Low product bits of two's complement operands equal those of the raw
  // unsigned product, so only the divider needs sign handling.
  always_ff @(posedge clk) begin
    if (reset || i_abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_div  <= 1'b0;
      r_neg  <= 1'b0;
      r_dz   <= 1'b0;
      r_acc  <= '0;
      r_q    <= '0;
      r_d    <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_div  <= (i_op == OP_DIV);
      r_neg  <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      r_dz   <= (i_b == '0);
      r_acc  <= '0;
      r_q    <= (i_op == OP_DIV) ? w_a_mag : i_b;
      r_d    <= (i_op == OP_DIV) ? w_b_mag : i_a;
    end else if (r_busy) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CW'(WIDTH - 1)) begin
        r_busy <= 1'b0;
      end
      if (r_div) begin
        r_acc <= w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
      end else begin
        r_acc <= r_acc + (r_q[0] ? r_d : '0);
        r_q   <= r_q >> 1;
        r_d   <= r_d << 1;
      end
    end
  end

  // Final result selection including the divide-by-zero convention
  always_comb begin
    o_done = r_busy && (r_cnt == CW'(WIDTH - 1));
    if (!r_div) begin
      o_result = r_acc;
    end else if (r_dz) begin
      o_result = '1;
    end else if (r_neg) begin
      o_result = -r_q;
    end else begin
      o_result = r_q;
    end
  end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: forwarding muxes, single-cycle ALU with registered outputs,
// and sequencing of the iterative MUL/DIV engine.
module execute_unit
  import exe_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MULDIV_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  input  logic [WIDTH-1:0] immediate,
  input  logic             ALUsrc,
  input  logic             dir,
  input  logic [3:0]       opcode,
  input  logic [1:0]       forwardA,
  input  logic [1:0]       forwardB,
  input  logic [WIDTH-1:0] alu_result_mem,
  input  logic [WIDTH-1:0] write_data_wb,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             branch_taken,
  output logic             out_valid,
  output logic             stall
);

  localparam int SW = $clog2(WIDTH);

  exe_state_e       r_state;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_fwd_b;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_md_result;
  logic             w_branch;
  logic             w_is_md;
  logic             w_md_start;
  logic             w_md_done;

  // Operand forwarding and immediate selection
  always_comb begin
    case (forwardA)
      FWD_WB:  w_op_a = write_data_wb;
      FWD_MEM: w_op_a = alu_result_mem;
      default: w_op_a = reg1;
    endcase
    case (forwardB)
      FWD_WB:  w_fwd_b = write_data_wb;
      FWD_MEM: w_fwd_b = alu_result_mem;
      default: w_fwd_b = reg2;
    endcase
    w_op_b = ALUsrc ? immediate : w_fwd_b;
  end

  // Single-cycle ALU; branches also produce A-B so zero reflects equality
  always_comb begin
    w_alu    = '0;
    w_branch = 1'b0;
    case (opcode)
      OP_ADD:   w_alu = w_op_a + w_op_b;
      OP_SUB:   w_alu = w_op_a - w_op_b;
      OP_AND:   w_alu = w_op_a & w_op_b;
      OP_OR:    w_alu = w_op_a | w_op_b;
      OP_XOR:   w_alu = w_op_a ^ w_op_b;
      OP_SHIFT: w_alu = dir ? (w_op_a >> w_op_b[SW-1:0]) : (w_op_a << w_op_b[SW-1:0]);
      OP_SLT:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      OP_BEQ: begin
        w_alu    = w_op_a - w_op_b;
        w_branch = (w_op_a == w_op_b);
      end
      OP_BNE: begin
        w_alu    = w_op_a - w_op_b;
        w_branch = (w_op_a != w_op_b);
      end
      default:  w_alu = '0;
    endcase
  end

  assign w_is_md    = (MULDIV_EN != 0) && is_muldiv(opcode);
  assign w_md_start = (r_state == ST_IDLE) && in_valid && w_is_md && !flush;
  assign stall      = (r_state != ST_IDLE);

  exe_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .i_abort  (flush),
    .i_start  (w_md_start),
    .i_op     (opcode),
    .i_a      (w_op_a),
    .i_b      (w_op_b),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  // Result registers and MUL/DIV sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      alu_result   <= '0;
      zero         <= 1'b0;
      branch_taken <= 1'b0;
      out_valid    <= 1'b0;
    end else if (flush) begin
      r_state      <= ST_IDLE;
      alu_result   <= '0;
      zero         <= 1'b0;
      out_valid    <= 1'b0;
      branch_taken <= (r_state == ST_IDLE) && in_valid && w_branch;
    end else begin
      case (r_state)
        ST_IDLE: begin
          branch_taken <= in_valid && w_branch;
          if (in_valid && w_is_md) begin
            r_state   <= ST_BUSY;
            out_valid <= 1'b0;
          end else if (in_valid) begin
            alu_result <= w_alu;
            zero       <= (w_alu == '0);
            out_valid  <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          branch_taken <= 1'b0;
          out_valid    <= 1'b0;
          if (w_md_done) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          alu_result   <= w_md_result;
          zero         <= (w_md_result == '0);
          branch_taken <= 1'b0;
          out_valid    <= 1'b1;
        end
        default: begin
          r_state   <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
